// File: rtl/mmio_timer_led_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_led_if
// Description : Core data-bus interface for the MMIO timer/LED block.
//               Requests are accepted combinationally (gnt_o) and are answered
//               exactly one cycle later with rvalid_o/rdata_o/err_o.
// Signals     : req_i, we_i, be_i[3:0], addr_i[31:0], wdata_i[31:0]  (core -> block)
//               gnt_o, rvalid_o, rdata_o[31:0], err_o              (block -> core)
// Modports    : master (core side), slave (peripheral side)
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_timer_led_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/mmio_timer_led.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_led
// Description : Memory-mapped LED register plus a 64-bit machine timer with
//               prescaler, compare register and level interrupt.
//               32-byte window at BASE_ADDR, word offsets addr_i[4:2]:
//                 0x00 LED  0x04 CTRL  0x08 STATUS(W1C)  0x0C/0x10 MTIME
//                 0x14/0x18 MTIMECMP  0x1C unmapped (error response)
// Ports       : clk_sys      - system clock, rising edge
//               rst_sys_n    - asynchronous active-low reset
//               bus          - data-bus slave (mmio_timer_led_if.slave)
//               led_o        - LED register contents
//               irq_timer_o  - level timer interrupt (PEND & IRQ_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer_led #(
  parameter logic [31:0] BASE_ADDR = 32'h0004_0000,
  parameter logic [31:0] LED_RESET = 32'h0000_0000
) (
  input  wire logic          clk_sys,
  input  wire logic          rst_sys_n,
  mmio_timer_led_if.slave    bus,
  output logic [31:0]        led_o,
  output logic               irq_timer_o
);

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_CTRL   = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_MTLO   = 3'd3;
  localparam logic [2:0] OFF_MTHI   = 3'd4;
  localparam logic [2:0] OFF_CMPLO  = 3'd5;
  localparam logic [2:0] OFF_CMPHI  = 3'd6;
  localparam logic [2:0] OFF_HOLE   = 3'd7;

  // Architectural state
  logic [31:0] led;
  logic        en;
  logic        irq_en;
  logic [7:0]  prescale;
  logic        pend;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [7:0]  pre_cnt;

  // Response registers
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  // Decode
  logic        gnt;
  logic        wr;
  logic [2:0]  off;
  logic [31:0] ctrl_word;
  logic [31:0] ctrl_new;
  logic [31:0] rd_word;
  logic        tick;
  logic        time_hit;
  logic        pend_clr;
  logic [63:0] mtime_nxt;
  logic        unused_addr_lsbs;

  // Byte-lane merge: only lanes with their enable set take the new data.
  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign gnt              = bus.req_i && (bus.addr_i[31:5] == BASE_ADDR[31:5]);
  assign off              = bus.addr_i[4:2];
  assign wr               = gnt && bus.we_i;
  assign unused_addr_lsbs = ^bus.addr_i[1:0];

  assign ctrl_word = {16'h0000, prescale, 6'b00_0000, irq_en, en};
  assign ctrl_new  = merge(ctrl_word, bus.wdata_i, bus.be_i);

  // Prescaler wraps at PRESCALE; the wrap cycle is the MTIME increment cycle.
  assign tick     = en && (pre_cnt == prescale);
  assign time_hit = (mtime >= mtimecmp);
  assign pend_clr = wr && (off == OFF_STATUS) && bus.be_i[0] && bus.wdata_i[0];

  always_comb begin
    rd_word = 32'h0000_0000;
    case (off)
      OFF_LED:    rd_word = led;
      OFF_CTRL:   rd_word = ctrl_word;
      OFF_STATUS: rd_word = {31'h0000_0000, pend};
      OFF_MTLO:   rd_word = mtime[31:0];
      OFF_MTHI:   rd_word = mtime[63:32];
      OFF_CMPLO:  rd_word = mtimecmp[31:0];
      OFF_CMPHI:  rd_word = mtimecmp[63:32];
      default:    rd_word = 32'h0000_0000;
    endcase
  end

  // A bus write to either MTIME half suppresses the increment for the whole
  // 64-bit counter, so software sees exactly the value it wrote.
  always_comb begin
    mtime_nxt = mtime;
    if (wr && (off == OFF_MTLO)) begin
      mtime_nxt[31:0] = merge(mtime[31:0], bus.wdata_i, bus.be_i);
    end else if (wr && (off == OFF_MTHI)) begin
      mtime_nxt[63:32] = merge(mtime[63:32], bus.wdata_i, bus.be_i);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      led      <= LED_RESET;
      en       <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= 8'h00;
      pend     <= 1'b0;
      mtime    <= 64'h0000_0000_0000_0000;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      pre_cnt  <= 8'h00;
      rvalid   <= 1'b0;
      rdata    <= 32'h0000_0000;
      err      <= 1'b0;
    end else begin
      // Bus response, one cycle after the grant
      rvalid <= gnt;
      err    <= gnt && (off == OFF_HOLE);
      rdata  <= (gnt && !bus.we_i) ? rd_word : 32'h0000_0000;

      // Register writes
      if (wr && (off == OFF_LED)) led <= merge(led, bus.wdata_i, bus.be_i);
      if (wr && (off == OFF_CTRL)) begin
        en       <= ctrl_new[0];
        irq_en   <= ctrl_new[1];
        prescale <= ctrl_new[15:8];
      end
      if (wr && (off == OFF_CMPLO)) mtimecmp[31:0]  <= merge(mtimecmp[31:0],  bus.wdata_i, bus.be_i);
      if (wr && (off == OFF_CMPHI)) mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.wdata_i, bus.be_i);

      // Timer
      if (!en)       pre_cnt <= 8'h00;
      else if (tick) pre_cnt <= 8'h00;
      else           pre_cnt <= pre_cnt + 8'd1;
      mtime <= mtime_nxt;

      // Compare on registered values; a match wins over a W1C in the same cycle
      pend <= time_hit | (pend & ~pend_clr);
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rdata;
  assign bus.err_o    = err;
  assign led_o        = led;
  assign irq_timer_o  = pend & irq_en;

endmodule
`default_nettype wire

// File: doc/mmio_timer_led.md
MMIO_TIMER_LED -- requirements
Module: mmio_timer_led

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0004_0000, the byte address of register offset 0x00; 32-byte window.
REQ-002 SHALL have parameter LED_RESET, default 32'h0000_0000, the reset value of the LED register.
REQ-003 clk_sys  in  1  system clock; all state SHALL be on its rising edge.
REQ-004 rst_sys_n  in  1  asynchronous active-low reset.
REQ-005 req_i  in  1  data-bus request from core.
REQ-006 we_i  in  1  1 = write, 0 = read.
REQ-007 be_i  in  4  byte enables for writes.
REQ-008 addr_i  in  32  byte address.
REQ-009 wdata_i  in  32  write data.
REQ-010 gnt_o  out  1  request accepted (combinational).
REQ-011 rvalid_o  out  1  response valid.
REQ-012 rdata_o  out  32  read data, qualified by rvalid_o.
REQ-013 err_o  out  1  error response, qualified by rvalid_o.
REQ-014 led_o  out  32  LED register contents.
REQ-015 irq_timer_o  out  1  level timer interrupt to core.

Function
REQ-016 gnt_o SHALL equal req_i AND (addr_i[31:5] == BASE_ADDR[31:5]); requests outside the window are not granted and cause no state change.
REQ-017 rvalid_o SHALL assert exactly one cycle after each granted cycle; back-to-back grants SHALL produce back-to-back rvalid pulses, with no stall and no reordering.
REQ-018 Register map (offset addr_i[4:2]):
- 0x00 LED RW.
- 0x04 CTRL RW: bit0 EN, bit1 IRQ_EN, bits[15:8] PRESCALE, other bits read 0.
- 0x08 STATUS: bit0 PEND, write-1-to-clear.
- 0x0C MTIME_LO RW; 0x10 MTIME_HI RW.
- 0x14 MTIMECMP_LO RW; 0x18 MTIMECMP_HI RW.
- 0x1C unmapped.
REQ-019 Writes SHALL update only bytes with be_i set; be_i = 4'b0000 is a no-op write that still gets a normal response.
REQ-020 A granted access to 0x1C SHALL return err_o = 1 with rvalid_o and rdata_o = 0, and SHALL have no write effect; err_o is 0 in all other cycles.
REQ-021 Read data SHALL be the register value before the grant-cycle clock edge, registered and presented with rvalid_o; write responses SHALL return rdata_o = 0.
REQ-022 Prescaler: 8-bit counter; when EN = 1 it counts 0..PRESCALE; on reaching PRESCALE it returns to 0 and MTIME increments by 1. PRESCALE = 0 means MTIME increments every cycle.
REQ-023 When EN = 0 the prescaler SHALL hold at 0 and MTIME SHALL hold.
REQ-024 MTIME SHALL be 64-bit, with carry from LO to HI, wrapping from all-ones to 0.
REQ-025 A bus write to MTIME_LO/HI in the same cycle as an increment SHALL take priority: the written word gets the enabled bytes, and the whole 64-bit MTIME suppresses that increment.
REQ-026 Each cycle PEND SHALL be set if MTIME >= MTIMECMP (unsigned 64-bit, registered values); set SHALL win over a simultaneous W1C clear.
REQ-027 irq_timer_o SHALL equal PEND AND IRQ_EN and SHALL be registered-state only (no combinational path from bus inputs).
REQ-028 led_o SHALL drive the LED register directly.

Reset
REQ-029 Asynchronous reset SHALL force:
- gnt-related state 0; rvalid_o = 0; err_o = 0; rdata_o = 0.
- LED = LED_RESET; CTRL = 0; PEND = 0; prescaler = 0.
- MTIME = 0; MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF.
- irq_timer_o = 0.
REQ-030 Reset asserted mid-transaction SHALL drop any pending rvalid_o; no response is produced for that access after reset release.

Verification
REQ-031 Write LED 0xA5A5_A5A5 with be_i = 4'b0011 after reset -> led_o = 0x0000_A5A5; read of 0x00 returns 0x0000_A5A5 one cycle after grant.
REQ-032 CTRL = 0x0000_0301 (EN, PRESCALE = 3) -> MTIME_LO increments once every 4 cycles; read after 40 enabled cycles returns 10 (±1 per the sampling edge).
REQ-033 MTIME = 0x0000_0000_FFFF_FFFF, PRESCALE = 0, EN = 1 -> next cycle MTIME_HI = 1, MTIME_LO = 0; all-ones MTIME wraps to 0.
REQ-034 MTIMECMP = 5, IRQ_EN = 1, EN = 1, PRESCALE = 0 -> irq_timer_o rises the cycle after MTIME reaches 5; W1C to STATUS while MTIME >= 5 leaves PEND = 1; raising MTIMECMP then W1C clears irq.
REQ-035 Back-to-back requests read 0x00, write 0x1C, read 0x04 -> three consecutive rvalid_o pulses, with err_o only on the second; a request at BASE_ADDR + 0x20 -> gnt_o = 0.
REQ-036 Assert rst_sys_n low in the cycle after a granted read -> rvalid_o = 0 immediately; all registers are at reset values on release.
